mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the data-RAM interface for the multi-cycle CPU: takes one load/store
//  request from the control unit and drives the word-wide RAM port. RAM has async read,
//  sync full-word write, word index = addr[12:2]. Sub-word stores use read-modify-write.
//  Loads return sign/zero-extended data. Sits between the control FSM/ALU and the data RAM.
// PARAMETERS
//  MEM_WORDS  2048  RAM depth in 32-bit words; word index addr[31:2] >= MEM_WORDS is an error
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req        in   1   request strobe; sampled only in IDLE
//  op         in   3   000 LW,001 LH,010 LHU,011 LB,100 LBU,101 SW,110 SH,111 SB
//  addr       in   32  byte address
//  wdata      in   32  store data; low byte/half used for SB/SH
//  busy       out  1   high in every state except IDLE
//  done       out  1   one-cycle completion pulse
//  err        out  1   valid with done: misaligned or out-of-range, no RAM access made
//  rdata_out  out  32  load result, valid from done cycle, held until next load completes
//  ram_we     out  1   RAM write enable
//  ram_addr   out  32  RAM address, always word-aligned {a[31:2],2'b00}
//  ram_wdata  out  32  RAM write data
//  ram_rdata  in   32  RAM async read data
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, err, ram_we = 0; rdata_out, ram_addr, ram_wdata = 0.
//  - Async reset mid-operation forces IDLE immediately, ram_we drops with reset.
//    No partial write. No done pulse.
//  - States: IDLE, RD, WR, DONE. ram_we is decoded from the registered state: high only in WR.
//  - IDLE & req: latch op, addr, wdata; ram_addr <= aligned addr. Next state:
//      - error detected -> DONE with err=1.
//      - load or SH/SB -> RD.
//      - SW -> WR.
//  - Error: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0; or addr[31:2] >= MEM_WORDS.
//  - RD: sample ram_rdata at the clock edge.
//      - Load: extract lane, extend into rdata_out, -> DONE.
//      - SH/SB: merge into ram_wdata, -> WR.
//  - WR: ram_we=1 for exactly one cycle with ram_addr/ram_wdata stable, -> DONE.
//  - DONE: done=1 (err as latched), -> IDLE. Request latency from accept cycle T:
//      - done at T+2 for load/SW.
//      - done at T+3 for SH/SB.
//      - done at T+1 on error.
//  - Byte lanes, little-endian: byte k = bits[8k+7:8k] with k=addr[1:0];
//    halfword at addr[1] = bits[16*addr[1]+15 : 16*addr[1]].
//  - LB/LH sign-extend; LBU/LHU zero-extend. SB/SH replace only the addressed lane.
//  - req while busy (including DONE) is ignored. Held req is re-accepted in the IDLE cycle
//    after done. Back-to-back throughput is one op per latency+1 cycles.
//  - rdata_out changes only on a successful load. Stores and errors leave it unchanged.
// TESTING
//  1. SW addr 0x10 wdata 0xDEADBEEF -> ram_we=1 only at T+1, ram_addr 0x10; done at T+2.
//     Then LW 0x10 -> rdata_out 0xDEADBEEF at done.
//  2. SB addr 0x11 wdata 0x000000AA -> WR at T+2 writes 0xDEADAAEF; done T+3.
//     LBU 0x11 -> 0x000000AA. LB 0x11 -> 0xFFFFFFAA.
//  3. SH addr 0x12 wdata 0x00008234 -> word 0x8234AAEF.
//     LH 0x12 -> 0xFFFF8234. LHU 0x12 -> 0x00008234. LH 0x10 -> 0xFFFFAAEF.
//  4. LW 0x13, SH 0x11, SW 0x2000 (word 2048) -> done+err at T+1; ram_we never high;
//     rdata_out unchanged.
//  5. rst_n low during the WR cycle of SB to 0x10 -> ram_we low same instant, busy=0,
//     no done; later LW 0x10 returns the old word.
//  6. req held high across two LW ops -> second accepted in the IDLE cycle after first done;
//     done pulses exactly 3 cycles apart.

Source files
------------

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Bundles the control-unit request/response signals and the
//            word-wide data-RAM port of the memory access unit.
// Modports : master - the memory access unit (RAM initiator)
//            slave  - the environment (control unit + data RAM)
// Signals  : req/op/addr/wdata            request from control unit
//            busy/done/err/rdata_out      status and load result
//            ram_we/ram_addr/ram_wdata    RAM write port (driven by unit)
//            ram_rdata                    RAM async read data
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata_out;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport master (
    input  req, op, addr, wdata, ram_rdata,
    output busy, done, err, rdata_out, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output req, op, addr, wdata, ram_rdata,
    input  busy, done, err, rdata_out, ram_we, ram_addr, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Executes one load/store request at a time against a word-wide
//            data RAM (async read, sync write). Sub-word stores are done as
//            read-modify-write; loads are sign/zero extended.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - mem_access_unit_if.master (request, status, RAM port)
// Params   : MEM_WORDS - RAM depth in 32-bit words
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int MEM_WORDS = 2048
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [31:0] C_MEM_WORDS = 32'(MEM_WORDS);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;

  logic [2:0]  r_op;
  logic [1:0]  r_lane;
  logic        r_err;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic [31:0] r_rdata_out;

  logic        w_accept;
  logic        w_misalign;
  logic        w_range_err;
  logic        w_req_err;
  logic        w_latched_load;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_load_val;
  logic [31:0] w_merge;

  assign w_accept       = (r_state == S_IDLE) && bus.req;
  assign w_latched_load = (r_op <= OP_LBU);

  // Request checks are evaluated on the live request so the error is known
  // in the accept cycle and no RAM access is ever started for it.
  always_comb begin
    w_misalign = 1'b0;
    case (bus.op)
      OP_LW, OP_SW:         w_misalign = (bus.addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: w_misalign = bus.addr[0];
      default:              w_misalign = 1'b0;
    endcase
  end

  assign w_range_err = ({2'b00, bus.addr[31:2]} >= C_MEM_WORDS);
  assign w_req_err   = w_misalign || w_range_err;

  // Lane extraction from the async read data, little-endian.
  assign w_half = r_lane[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
  assign w_byte = bus.ram_rdata[{r_lane, 3'b000} +: 8];

  always_comb begin
    w_load_val = bus.ram_rdata;
    case (r_op)
      OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_val = {16'h0000, w_half};
      OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_val = {24'h000000, w_byte};
      default: w_load_val = bus.ram_rdata;
    endcase
  end

  // Read-modify-write merge: r_ram_wdata still holds the raw store data
  // captured at accept, so its low byte/half is the lane to insert.
  always_comb begin
    w_merge = bus.ram_rdata;
    if (r_op == OP_SB) begin
      w_merge[{r_lane, 3'b000} +: 8] = r_ram_wdata[7:0];
    end else if (r_op == OP_SH) begin
      w_merge[{r_lane[1], 4'b0000} +: 16] = r_ram_wdata[15:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (w_req_err) begin
            w_next_state = S_DONE;
          end else if (bus.op == OP_SW) begin
            w_next_state = S_WR;
          end else begin
            w_next_state = S_RD;
          end
        end
      end
      S_RD:    w_next_state = w_latched_load ? S_DONE : S_WR;
      S_WR:    w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only, so ram_we falls
  // together with an asynchronous reset.
  always_comb begin
    bus.busy   = (r_state != S_IDLE);
    bus.done   = (r_state == S_DONE);
    bus.err    = (r_state == S_DONE) && r_err;
    bus.ram_we = (r_state == S_WR);
  end

  // Request capture and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= OP_LW;
      r_lane      <= 2'b00;
      r_err       <= 1'b0;
      r_ram_addr  <= 32'h0000_0000;
      r_ram_wdata <= 32'h0000_0000;
      r_rdata_out <= 32'h0000_0000;
    end else begin
      if (w_accept) begin
        r_op        <= bus.op;
        r_lane      <= bus.addr[1:0];
        r_err       <= w_req_err;
        r_ram_addr  <= {bus.addr[31:2], 2'b00};
        r_ram_wdata <= bus.wdata;
      end else if (r_state == S_RD) begin
        if (w_latched_load) begin
          r_rdata_out <= w_load_val;
        end else begin
          r_ram_wdata <= w_merge;
        end
      end
    end
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.rdata_out = r_rdata_out;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit: directed vector table,
//            reset-during-write and held-request sequences, then random ops
//            checked against a byte-level reference memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int NW = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_WORDS(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data RAM: async read, sync write.
  logic [31:0] ram  [0:NW-1];
  logic [31:0] rmem [0:NW-1];
  assign bus.ram_rdata = ram[bus.ram_addr[12:2]];
  always @(posedge clk) if (bus.ram_we) ram[bus.ram_addr[12:2]] <= bus.ram_wdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_rdata;  // expected rdata_out

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model: computes expectations from the byte-level rules and
  // updates the model memory / expected load result.
  task automatic model_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic e_err, output int e_lat, output logic [31:0] e_word,
                          output logic e_store);
    logic [31:0] word, v, mask;
    int idx, k;
    e_store = (op >= 3'd5);
    e_word  = 32'h0;
    k   = int'(addr % 4);
    e_err = ((addr >> 2) >= NW);
    if ((op == 3'd0 || op == 3'd5) && k != 0) e_err = 1'b1;
    if ((op == 3'd1 || op == 3'd2 || op == 3'd6) && (k % 2) != 0) e_err = 1'b1;
    if (e_err) begin
      e_lat = 1;
      return;
    end
    idx  = int'(addr >> 2);
    word = rmem[idx];
    case (op)
      3'd0: begin m_rdata = word; e_lat = 2; end
      3'd1, 3'd2: begin
        v = (word >> (8 * k)) & 32'hFFFF;
        if (op == 3'd1 && v >= 32'd32768) v = v - 32'h10000;
        m_rdata = v; e_lat = 2;
      end
      3'd3, 3'd4: begin
        v = (word >> (8 * k)) & 32'hFF;
        if (op == 3'd3 && v >= 32'd128) v = v - 32'h100;
        m_rdata = v; e_lat = 2;
      end
      3'd5: begin e_word = wdata; e_lat = 2; end
      3'd6: begin
        mask = 32'hFFFF << (8 * k);
        e_word = (word & ~mask) | ((wdata & 32'hFFFF) << (8 * k)); e_lat = 3;
      end
      default: begin
        mask = 32'hFF << (8 * k);
        e_word = (word & ~mask) | ((wdata & 32'hFF) << (8 * k)); e_lat = 3;
      end
    endcase
    if (e_store) rmem[idx] = e_word;
  endtask

  // Issue one request from IDLE and check timing, write port and result.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic e_err, input logic [31:0] e_rd,
                       input int e_lat, input logic [31:0] e_word, input logic e_store);
    int n, we_cnt;
    logic seen;
    n = 0; we_cnt = 0; seen = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.op = op; bus.addr = addr; bus.wdata = wdata;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) bus.req = 1'b0;
      if (bus.ram_we) begin
        we_cnt++;
        check({tag, "_we_cycle"}, 32'(n), 32'(e_lat - 1));
        check({tag, "_ram_addr"}, bus.ram_addr, {addr[31:2], 2'b00});
        check({tag, "_ram_wdata"}, bus.ram_wdata, e_word);
      end
      if (bus.done) begin seen = 1'b1; break; end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(e_lat));
    check({tag, "_err"}, 32'(bus.err), 32'(e_err));
    check({tag, "_rdata"}, bus.rdata_out, e_rd);
    check({tag, "_we_count"}, 32'(we_cnt), (e_store && !e_err) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    logic [31:0] e_word;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic        me;
    int          ml;
    logic [31:0] mw;
    logic        ms;
    logic [2:0]  rop;
    logic [31:0] raddr, rwd;
    int          t1, t2, ndone, sel, nbad;

    for (int i = 0; i < NW; i++) begin ram[i] <= 32'h0; rmem[i] = 32'h0; end
    m_rdata = 32'h0;
    bus.req = 1'b0; bus.op = 3'd0; bus.addr = 32'h0; bus.wdata = 32'h0;

    vt[0]  = '{3'd5, 32'h10,   32'hDEADBEEF, 1'b0, 32'h00000000, 2, 32'hDEADBEEF};
    vt[1]  = '{3'd0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 2, 32'h0};
    vt[2]  = '{3'd7, 32'h11,   32'h000000AA, 1'b0, 32'hDEADBEEF, 3, 32'hDEADAAEF};
    vt[3]  = '{3'd4, 32'h11,   32'h0,        1'b0, 32'h000000AA, 2, 32'h0};
    vt[4]  = '{3'd3, 32'h11,   32'h0,        1'b0, 32'hFFFFFFAA, 2, 32'h0};
    vt[5]  = '{3'd6, 32'h12,   32'h00008234, 1'b0, 32'hFFFFFFAA, 3, 32'h8234AAEF};
    vt[6]  = '{3'd1, 32'h12,   32'h0,        1'b0, 32'hFFFF8234, 2, 32'h0};
    vt[7]  = '{3'd2, 32'h12,   32'h0,        1'b0, 32'h00008234, 2, 32'h0};
    vt[8]  = '{3'd1, 32'h10,   32'h0,        1'b0, 32'hFFFFAAEF, 2, 32'h0};
    vt[9]  = '{3'd0, 32'h13,   32'h0,        1'b1, 32'hFFFFAAEF, 1, 32'h0};
    vt[10] = '{3'd6, 32'h11,   32'h1234,     1'b1, 32'hFFFFAAEF, 1, 32'h0};
    vt[11] = '{3'd5, 32'h2000, 32'h55555555, 1'b1, 32'hFFFFAAEF, 1, 32'h0};
    vt[12] = '{3'd0, 32'h10,   32'h0,        1'b0, 32'h8234AAEF, 2, 32'h0};

    // Reset state, both during and after reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_status", {28'd0, bus.busy, bus.done, bus.err, bus.ram_we}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rdata_out", bus.rdata_out, 32'h0);
    check("rst_ram_addr", bus.ram_addr, 32'h0);
    check("rst_ram_wdata", bus.ram_wdata, 32'h0);
    check("idle_status", {28'd0, bus.busy, bus.done, bus.err, bus.ram_we}, 32'd0);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      model_op(vt[i].op, vt[i].addr, vt[i].wdata, me, ml, mw, ms);
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].addr, vt[i].wdata,
            vt[i].e_err, vt[i].e_rd, vt[i].e_lat, vt[i].e_word, ms);
    end

    // Reset asserted during the WR cycle of an SB: no write, no done.
    @(negedge clk);
    bus.req = 1'b1; bus.op = 3'd7; bus.addr = 32'h10; bus.wdata = 32'h55;
    @(posedge clk); #1; bus.req = 1'b0;
    @(posedge clk); #1;
    check("rstwr_we_before", 32'(bus.ram_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwr_status", {28'd0, bus.busy, bus.done, bus.err, bus.ram_we}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.done) ndone++; end
    check("rstwr_no_done", 32'(ndone), 32'd0);
    m_rdata = 32'h0;
    check("rstwr_rdata_cleared", bus.rdata_out, 32'h0);
    model_op(3'd0, 32'h10, 32'h0, me, ml, mw, ms);
    do_op("rstwr_lw", 3'd0, 32'h10, 32'h0, me, m_rdata, ml, mw, ms);

    // Held request across two LWs.
    model_op(3'd0, 32'h10, 32'h0, me, ml, mw, ms);
    @(negedge clk);
    bus.req = 1'b1; bus.op = 3'd0; bus.addr = 32'h10;
    t1 = -1; t2 = -1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (t1 < 0) t1 = c;
        else begin t2 = c; bus.req = 1'b0; break; end
      end
    end
    bus.req = 1'b0;
    check("held_first_done", 32'(t1), 32'd2);
    check("held_spacing", 32'(t2 - t1), 32'd3);
    check("held_rdata", bus.rdata_out, m_rdata);
    @(posedge clk); #1;

    // Random operations against the reference model.
    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel == 0)      raddr = $urandom;
      else if (sel == 1) raddr = 32'h1FFC + 32'($urandom_range(0, 8));
      else               raddr = 32'($urandom_range(0, 127));
      rwd = $urandom;
      model_op(rop, raddr, rwd, me, ml, mw, ms);
      do_op($sformatf("rnd%0d", i), rop, raddr, rwd, me, m_rdata, ml, mw, ms);
    end

    nbad = 0;
    for (int i = 0; i < NW; i++) if (ram[i] !== rmem[i]) nbad++;
    check("final_mem_words_differing", 32'(nbad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
